fetch_stage: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the instruction cache.
- Owns the architectural fetch PC and drives the cache lookup address. Consumes the cache's 64-bit line (two 32-bit instructions) when the cache reports a hit.
- Buffers fetched instructions with their PCs in a small 2-in/2-out instruction buffer feeding decode.
- Handles back-end redirects (branch mispredict, exception) by flushing and reloading the PC.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stage_inst_buffer.sv | 56 +++++
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   IB_DEPTH      default instruction buffer depth
//   INST_BYTES    bytes per instruction
//   LINE_BYTES    bytes per cache line (two instructions)
//   fetch_entry_t one buffered instruction with its PC
package fetch_pkg;
   localparam int IB_DEPTH   = 8;
   localparam int INST_BYTES = 4;
   localparam int LINE_BYTES = 8;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_inst_buffer.sv
// inst_buffer: circular FIFO of fetch entries, 0-2 pushes and 0-2 pops per cycle.
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   flush         synchronous flush, overrides push and pop
//   push_num      entries written this cycle (caller guarantees space)
//   push_entries  [0] written first, [1] second
//   pop_num       entries retired this cycle (caller guarantees <= count)
//   head_entries  [0] oldest, [1] second oldest; zero when not present
//   count         current occupancy
module inst_buffer
   import fetch_pkg::*;
#(
   parameter  int DEPTH = IB_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic [1:0]    push_num,
   input  fetch_entry_t  push_entries [2],
   input  logic [1:0]    pop_num,
   output fetch_entry_t  head_entries [2],
   output logic [CW-1:0] count
);
   logic [AW-1:0] head, tail;
   fetch_entry_t  mem [DEPTH];

   // pointer width is exactly log2(DEPTH), so wrap modulo DEPTH is free
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop_num);
         tail  <= tail + AW'(push_num);
         count <= count + CW'(push_num) - CW'(pop_num);
      end
   end

   // storage needs no reset: occupancy gates everything that is visible
   always_ff @(posedge clock) begin
      if (!flush) begin
         if (push_num != 2'd0) mem[tail] <= push_entries[0];
         if (push_num == 2'd2) mem[tail + AW'(1)] <= push_entries[1];
      end
   end

   assign head_entries[0] = count != '0 ? mem[head] : '0;
   assign head_entries[1] = count >= CW'(2) ? mem[head + AW'(1)] : '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC owner, icache address generation and instruction buffering.
//   clock / reset      rising-edge clock, asynchronous active-low reset
//   Icache_data_out    64-bit line: [31:0] at +0, [63:32] at +4
//   Icache_valid_out   line hit for the current lookup address
//   proc2Icache_addr   line-aligned lookup address
//   redirect_valid/pc  back-end redirect (highest priority, flushes buffer)
//   dec_pop_num        instructions decode takes this cycle (clamped)
//   ib_valid_num       min(count, 2)
//   ib_inst0/1, ib_pc0/1  oldest two buffered instructions and their PCs
//   ib_count           buffer occupancy
module fetch_stage #(
   parameter  logic [63:0] RESET_PC = 64'h0,
   parameter  int          IB_DEPTH = fetch_pkg::IB_DEPTH,
   localparam int          CW       = $clog2(IB_DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [63:0]   Icache_data_out,
   input  logic          Icache_valid_out,
   output logic [63:0]   proc2Icache_addr,
   input  logic          redirect_valid,
   input  logic [63:0]   redirect_pc,
   input  logic [1:0]    dec_pop_num,
   output logic [1:0]    ib_valid_num,
   output logic [31:0]   ib_inst0,
   output logic [31:0]   ib_inst1,
   output logic [63:0]   ib_pc0,
   output logic [63:0]   ib_pc1,
   output logic [CW-1:0] ib_count
);
   import fetch_pkg::*;

   logic [63:0]   pc, line_addr;
   logic [1:0]    fetch_n, push_num, valid_num, pop_eff;
   logic [CW-1:0] count, free;
   logic          push;
   fetch_entry_t  push_entries [2];
   fetch_entry_t  head_entries [2];

   assign line_addr = pc & ~64'h7;
   assign proc2Icache_addr = line_addr;

   // an odd-word PC only has the upper half of its line left to fetch
   assign fetch_n  = pc[2] ? 2'd1 : 2'd2;
   // space is judged on pre-pop occupancy, so a same-cycle pop never makes room
   assign free     = CW'(IB_DEPTH) - count;
   assign push     = Icache_valid_out && !redirect_valid && free >= CW'(fetch_n);
   assign push_num = push ? fetch_n : 2'd0;

   assign push_entries[0] = {pc, pc[2] ? Icache_data_out[63:32] : Icache_data_out[31:0]};
   assign push_entries[1] = {pc + 64'(INST_BYTES), Icache_data_out[63:32]};

   assign valid_num = count >= CW'(2) ? 2'd2 : count[1:0];
   assign pop_eff   = redirect_valid ? 2'd0 : dec_pop_num > valid_num ? valid_num : dec_pop_num;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) pc <= RESET_PC & ~64'h3;
      else if (redirect_valid) pc <= redirect_pc & ~64'h3;
      else if (push) pc <= line_addr + 64'(LINE_BYTES);
   end

   inst_buffer #(.DEPTH(IB_DEPTH)) u_ib (
      .clock        (clock),
      .reset        (reset),
      .flush        (redirect_valid),
      .push_num     (push_num),
      .push_entries (push_entries),
      .pop_num      (pop_eff),
      .head_entries (head_entries),
      .count        (count)
   );

   assign ib_valid_num = valid_num;
   assign ib_count     = count;
   assign ib_inst0     = head_entries[0].inst;
   assign ib_pc0       = head_entries[0].pc;
   assign ib_inst1     = head_entries[1].inst;
   assign ib_pc1       = head_entries[1].pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a queue-based model.
module tb_fetch_stage;
   localparam logic [63:0] RPC = 64'h100;
   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] Icache_data_out = '0;
   logic        Icache_valid_out = 1'b0;
   logic [63:0] proc2Icache_addr;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic [1:0]  dec_pop_num = '0;
   logic [1:0]  ib_valid_num;
   logic [31:0] ib_inst0, ib_inst1;
   logic [63:0] ib_pc0, ib_pc1;
   logic [3:0]  ib_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] qpc [$];
   logic [31:0] qinst [$];
   logic [63:0] mpc;

   fetch_stage #(.RESET_PC(RPC), .IB_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
      .proc2Icache_addr(proc2Icache_addr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_pop_num(dec_pop_num), .ib_valid_num(ib_valid_num),
      .ib_inst0(ib_inst0), .ib_inst1(ib_inst1), .ib_pc0(ib_pc0), .ib_pc1(ib_pc1),
      .ib_count(ib_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      int n = qpc.size();
      chk({tag, ".count"}, 64'(ib_count), 64'(n));
      chk({tag, ".vnum"}, 64'(ib_valid_num), 64'(n > 2 ? 2 : n));
      chk({tag, ".addr"}, proc2Icache_addr, mpc & ~64'h7);
      chk({tag, ".inst0"}, 64'(ib_inst0), n > 0 ? 64'(qinst[0]) : 64'h0);
      chk({tag, ".pc0"}, ib_pc0, n > 0 ? qpc[0] : 64'h0);
      chk({tag, ".inst1"}, 64'(ib_inst1), n > 1 ? 64'(qinst[1]) : 64'h0);
      chk({tag, ".pc1"}, ib_pc1, n > 1 ? qpc[1] : 64'h0);
   endtask

   // one clock: apply inputs, check current state, advance model at the edge
   task automatic cycle(input string tag, input logic v, input logic [63:0] d,
                        input logic r, input logic [63:0] rp, input logic [1:0] p);
      int vn, pe;
      Icache_valid_out = v;
      Icache_data_out  = d;
      redirect_valid   = r;
      redirect_pc      = rp;
      dec_pop_num      = p;
      chk_model(tag);
      @(posedge clock);
      if (r) begin
         qpc.delete();
         qinst.delete();
         mpc = rp & ~64'h3;
      end else begin
         vn = qpc.size() > 2 ? 2 : qpc.size();
         pe = int'(p) > vn ? vn : int'(p);
         if (v && (DEPTH - qpc.size()) >= (mpc[2] ? 1 : 2)) begin
            if (mpc[2]) begin
               qpc.push_back(mpc);
               qinst.push_back(d[63:32]);
            end else begin
               qpc.push_back(mpc);
               qinst.push_back(d[31:0]);
               qpc.push_back(mpc + 4);
               qinst.push_back(d[63:32]);
            end
            mpc = (mpc & ~64'h7) + 8;
         end
         repeat (pe) begin
            void'(qpc.pop_front());
            void'(qinst.pop_front());
         end
      end
      #1;
   endtask

   localparam logic [63:0] LINE = 64'hBBBB_0002_AAAA_0001;

   initial begin
      mpc = RPC;
      #12;
      chk("rst.addr", proc2Icache_addr, 64'h100);
      chk("rst.count", 64'(ib_count), 64'h0);
      chk_model("rst");
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      cycle("fill0", 1, LINE, 0, 0, 0);
      chk("fill.inst0", 64'(ib_inst0), 64'hAAAA0001);
      chk("fill.pc0", ib_pc0, 64'h100);
      chk("fill.inst1", 64'(ib_inst1), 64'hBBBB0002);
      chk("fill.pc1", ib_pc1, 64'h104);
      for (int i = 0; i < 5; i++) cycle("fill", 1, LINE, 0, 0, 0);
      chk("full.count", 64'(ib_count), 64'd8);
      chk("full.addr", proc2Icache_addr, 64'h120);
      cycle("redir20c", 1, LINE, 1, 64'h20C, 0);
      cycle("odd", 1, LINE, 0, 0, 0);
      chk("odd.count", 64'(ib_count), 64'd1);
      chk("odd.addr", proc2Icache_addr, 64'h210);
      chk("odd.inst0", 64'(ib_inst0), 64'hBBBB0002);
      cycle("redir40", 0, 0, 1, 64'h43, 0);
      for (int i = 0; i < 5; i++) begin
         cycle("miss", 0, {$urandom, $urandom}, 0, 0, 0);
         chk("miss.addr", proc2Icache_addr, 64'h40);
      end
      cycle("hit40", 1, 64'h2222_2222_1111_1111, 0, 0, 0);
      chk("hit40.count", 64'(ib_count), 64'd2);
      cycle("r1004", 0, 0, 1, 64'h1004, 0);
      for (int i = 0; i < 4; i++) cycle("to7", 1, {$urandom, $urandom}, 0, 0, 0);
      chk("c7.count", 64'(ib_count), 64'd7);
      cycle("c7pop", 1, LINE, 0, 0, 2);
      chk("c7.count5", 64'(ib_count), 64'd5);
      chk("c7.addr", proc2Icache_addr, 64'h1020);
      cycle("c6", 1, {$urandom, $urandom}, 0, 0, 1);
      cycle("c6", 0, 0, 0, 0, 0);
      chk("c6.count", 64'(ib_count), 64'd6);
      cycle("c6redir", 1, LINE, 1, 64'h3337, 2);
      chk("redir.count", 64'(ib_count), 64'd0);
      chk("redir.vnum", 64'(ib_valid_num), 64'd0);
      chk("redir.addr", proc2Icache_addr, 64'h3330);
      cycle("one", 1, LINE, 0, 0, 0);
      chk("one.count", 64'(ib_count), 64'd1);
      cycle("over", 0, 0, 0, 0, 2);
      chk("over.count", 64'(ib_count), 64'd0);
      cycle("wrap", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      cycle("wrap", 1, LINE, 0, 0, 0);
      chk("wrap.addr", proc2Icache_addr, 64'h0);
      for (int i = 0; i < 400; i++) begin
         logic r = ($urandom_range(0, 15) == 0);
         cycle("rand", $urandom_range(0, 3) != 0, {$urandom, $urandom}, r,
               {$urandom, $urandom}, 2'($urandom_range(0, 2)));
      end
      cycle("pre_rst", 1, LINE, 0, 0, 0);
      Icache_valid_out = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      qpc.delete();
      qinst.delete();
      mpc = RPC;
      chk("mid_rst.addr", proc2Icache_addr, 64'h100);
      chk("mid_rst.count", 64'(ib_count), 64'h0);
      chk_model("mid_rst");
      @(posedge clock); #1;
      chk_model("held_rst");
      reset = 1'b1;
      cycle("post_rst", 1, LINE, 0, 0, 0);
      chk_model("post_rst");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
